// File: rtl/sprite_video_engine_if.sv
// Object configuration bus for the sprite engine: per-object geometry/colour,
// background colour and the update_req/update_ack shadow-load handshake.
interface sprite_video_engine_if #(
    parameter int NUM_OBJ = 4,
    parameter int CW      = 8
);
    logic [NUM_OBJ*11-1:0]   obj_x;
    logic [NUM_OBJ*10-1:0]   obj_y;
    logic [NUM_OBJ*11-1:0]   obj_w;
    logic [NUM_OBJ*10-1:0]   obj_h;
    logic [NUM_OBJ-1:0]      obj_en;
    logic [NUM_OBJ*3*CW-1:0] obj_rgb;
    logic [3*CW-1:0]         bg_rgb;
    logic                    update_req;
    logic                    update_ack;

    modport master (
        output obj_x, obj_y, obj_w, obj_h, obj_en, obj_rgb, bg_rgb, update_req,
        input  update_ack
    );

    modport slave (
        input  obj_x, obj_y, obj_w, obj_h, obj_en, obj_rgb, bg_rgb, update_req,
        output update_ack
    );
endinterface

// File: rtl/sprite_video_engine.sv
// Raster timing generator with NUM_OBJ priority-ordered rectangles drawn from
// frame-synchronous shadow registers, through a two-stage hit/colour pipeline.
module sprite_video_engine #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int NUM_OBJ  = 4,
    parameter int CW       = 8
) (
    input  logic                 pixel_clock,
    input  logic                 reset,
    sprite_video_engine_if.slave cfg,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 blank,
    output logic [CW-1:0]        red,
    output logic [CW-1:0]        green,
    output logic [CW-1:0]        blue,
    output logic                 frame_start
);
    localparam int PW = 3 * CW;
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_q;
    logic [9:0]  v_q;

    logic [NUM_OBJ*11-1:0] sh_x_q, sh_w_q;
    logic [NUM_OBJ*10-1:0] sh_y_q, sh_h_q;
    logic [NUM_OBJ-1:0]    sh_en_q;
    logic [NUM_OBJ*PW-1:0] sh_rgb_q;
    logic                  ack_q;
    logic                  load;

    logic [NUM_OBJ-1:0] hit_d, hit_p1_q;
    logic               hs_d, vs_d, blank_d, fs_d;
    logic               hs_p1_q, vs_p1_q, blank_p1_q, fs_p1_q;
    logic [PW-1:0]      col_d, col_p2_q;
    logic               hs_p2_q, vs_p2_q, blank_p2_q, fs_p2_q;

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end else begin
            h_q <= h_q + 11'd1;
        end
    end

    // Shadows swap only at the top of vertical blanking so a frame never tears.
    assign load           = (h_q == '0) && (v_q == V_ACT) && cfg.update_req;
    assign cfg.update_ack = ack_q;

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            sh_x_q   <= '0;
            sh_y_q   <= '0;
            sh_w_q   <= '0;
            sh_h_q   <= '0;
            sh_en_q  <= '0;
            sh_rgb_q <= '0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= load;
            if (load) begin
                sh_x_q   <= cfg.obj_x;
                sh_y_q   <= cfg.obj_y;
                sh_w_q   <= cfg.obj_w;
                sh_h_q   <= cfg.obj_h;
                sh_en_q  <= cfg.obj_en;
                sh_rgb_q <= cfg.obj_rgb;
            end
        end
    end

    // Stage 1: hit vector and raw timing; end sums widened so x+w / y+h never wrap.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit_d[i] = sh_en_q[i]
                && (h_q >= sh_x_q[11*i +: 11])
                && ({1'b0, h_q} < ({1'b0, sh_x_q[11*i +: 11]} + {1'b0, sh_w_q[11*i +: 11]}))
                && (v_q >= sh_y_q[10*i +: 10])
                && ({1'b0, v_q} < ({1'b0, sh_y_q[10*i +: 10]} + {1'b0, sh_h_q[10*i +: 10]}));
        end
    end

    assign hs_d    = !((h_q >= HS_BEG) && (h_q < HS_END));
    assign vs_d    = !((v_q >= VS_BEG) && (v_q < VS_END));
    assign blank_d = (h_q >= H_ACT) || (v_q >= V_ACT);
    assign fs_d    = (h_q == '0) && (v_q == '0);

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            hit_p1_q   <= '0;
            hs_p1_q    <= 1'b1;
            vs_p1_q    <= 1'b1;
            blank_p1_q <= 1'b1;
            fs_p1_q    <= 1'b0;
        end else begin
            hit_p1_q   <= hit_d;
            hs_p1_q    <= hs_d;
            vs_p1_q    <= vs_d;
            blank_p1_q <= blank_d;
            fs_p1_q    <= fs_d;
        end
    end

    // Stage 2: lowest-index hit wins, so scan from the top index downwards.
    always_comb begin
        col_d = cfg.bg_rgb;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit_p1_q[i]) col_d = sh_rgb_q[PW*i +: PW];
        end
        if (blank_p1_q) col_d = '0;
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            col_p2_q   <= '0;
            hs_p2_q    <= 1'b1;
            vs_p2_q    <= 1'b1;
            blank_p2_q <= 1'b1;
            fs_p2_q    <= 1'b0;
        end else begin
            col_p2_q   <= col_d;
            hs_p2_q    <= hs_p1_q;
            vs_p2_q    <= vs_p1_q;
            blank_p2_q <= blank_p1_q;
            fs_p2_q    <= fs_p1_q;
        end
    end

    assign red         = col_p2_q[3*CW-1:2*CW];
    assign green       = col_p2_q[2*CW-1:CW];
    assign blue        = col_p2_q[CW-1:0];
    assign hsync       = hs_p2_q;
    assign vsync       = vs_p2_q;
    assign blank       = blank_p2_q;
    assign frame_start = fs_p2_q;
endmodule

// File: tb/tb_sprite_video_engine.sv
// Directed bench for sprite_video_engine on a shrunken 24x17 raster (16x12 active)
// so that several whole frames fit in a few thousand cycles.
module tb_sprite_video_engine;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [31:0] BG = 32'h000020;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic hsync, vsync, blank, frame_start;
    logic [7:0] red, green, blue;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int rel_cyc, fs0_cyc;

    // Reference raster position: counters (th,tv) and the position now at the outputs.
    int th = 0, tv = 0, oh1 = 0, ov1 = 0, oh2 = 0, ov2 = 0;
    bit v1 = 1'b0, v2 = 1'b0;

    sprite_video_engine_if #(.NUM_OBJ(4), .CW(8)) cfg ();

    sprite_video_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .NUM_OBJ(4), .CW(8)
    ) dut (
        .pixel_clock(clk),
        .reset(reset),
        .cfg(cfg.slave),
        .hsync(hsync),
        .vsync(vsync),
        .blank(blank),
        .red(red),
        .green(green),
        .blue(blue),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            th <= 0; tv <= 0; oh1 <= 0; ov1 <= 0; oh2 <= 0; ov2 <= 0;
            v1 <= 1'b0; v2 <= 1'b0;
        end else begin
            if (th == HT - 1) begin
                th <= 0;
                tv <= (tv == VT - 1) ? 0 : tv + 1;
            end else begin
                th <= th + 1;
            end
            oh1 <= th; ov1 <= tv; oh2 <= oh1; ov2 <= ov1;
            v1 <= 1'b1; v2 <= v1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input int h, input int v);
        for (int n = 0; n < 3 * FRAME; n++) begin
            if (v2 && oh2 == h && ov2 == v) return;
            @(negedge clk);
        end
        errs++;
        $error("FAIL timeout waiting for output pixel (%0d,%0d)", h, v);
    endtask

    task automatic wait_ctr(input int h, input int v);
        for (int n = 0; n < 3 * FRAME; n++) begin
            if (!reset && th == h && tv == v) return;
            @(negedge clk);
        end
        errs++;
        $error("FAIL timeout waiting for counter (%0d,%0d)", h, v);
    endtask

    function automatic logic [31:0] rgb();
        return 32'({red, green, blue});
    endfunction

    initial begin
        cfg.obj_x      = {11'd1, 11'd14, 11'd7, 11'd5};
        cfg.obj_y      = {10'd1, 10'd0, 10'd4, 10'd3};
        cfg.obj_w      = {11'd0, 11'd6, 11'd3, 11'd4};
        cfg.obj_h      = {10'd5, 10'd12, 10'd3, 10'd2};
        cfg.obj_en     = 4'b1111;
        cfg.obj_rgb    = {24'h123456, 24'h0000FF, 24'h00FF00, 24'hFF0000};
        cfg.bg_rgb     = 24'h000020;
        cfg.update_req = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_rgb", rgb(), 32'd0);
        chk("rst_ack", 32'(cfg.update_ack), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        reset   = 1'b0;
        rel_cyc = cyc;

        // Frame 0: shadows still zero, timing checks.
        wait_out(0, 0);
        chk("f0_fs", 32'(frame_start), 32'd1);
        chk("f0_fs_lat", 32'(cyc - rel_cyc), 32'd2);
        chk("f0_blank00", 32'(blank), 32'd0);
        chk("f0_bg00", rgb(), BG);
        fs0_cyc = cyc;
        wait_out(1, 0);  chk("f0_fs_off", 32'(frame_start), 32'd0);
        wait_out(17, 0); chk("hs_17", 32'(hsync), 32'd1);
        wait_out(18, 0); chk("hs_18", 32'(hsync), 32'd0);
        wait_out(20, 0); chk("hs_20", 32'(hsync), 32'd0);
        wait_out(21, 0); chk("hs_21", 32'(hsync), 32'd1);
        wait_out(5, 3);  chk("f0_shadow_zero", rgb(), BG);
        wait_ctr(1, VA); chk("f0_ack", 32'(cfg.update_ack), 32'd1);
        cfg.update_req = 1'b0;
        wait_ctr(2, VA); chk("f0_ack_single", 32'(cfg.update_ack), 32'd0);
        wait_out(0, VA);
        chk("vblank", 32'(blank), 32'd1);
        chk("vblank_rgb", rgb(), 32'd0);
        chk("vs_12", 32'(vsync), 32'd1);
        wait_out(0, 13); chk("vs_13", 32'(vsync), 32'd0);
        wait_out(0, 14); chk("vs_14", 32'(vsync), 32'd0);
        wait_out(0, 15); chk("vs_15", 32'(vsync), 32'd1);

        // Frame 1: loaded objects, priority, clipping, zero width.
        wait_out(0, 0);
        chk("f1_fs", 32'(frame_start), 32'd1);
        chk("fs_period", 32'(cyc - fs0_cyc), 32'(FRAME));
        wait_out(1, 1);  chk("w0_invisible", rgb(), BG);
        wait_out(15, 1); chk("clip_edge", rgb(), 32'h0000FF);
        wait_out(16, 1);
        chk("clip_blank", 32'(blank), 32'd1);
        chk("clip_blank_rgb", rgb(), 32'd0);
        wait_out(0, 2);  chk("no_wrap", rgb(), BG);
        cfg.obj_x[10:0] = 11'd2;
        wait_out(5, 3);  chk("obj0_left", rgb(), 32'hFF0000);
        wait_out(8, 3);  chk("obj0_right", rgb(), 32'hFF0000);
        wait_out(9, 3);  chk("obj0_past", rgb(), BG);
        wait_out(7, 4);  chk("overlap_obj0", rgb(), 32'hFF0000);
        wait_out(9, 4);  chk("obj1_only", rgb(), 32'h00FF00);
        wait_out(7, 5);  chk("obj0_below", rgb(), 32'h00FF00);
        wait_ctr(1, VA); chk("f1_no_ack", 32'(cfg.update_ack), 32'd0);

        // Frame 2: live x change without request must not show.
        wait_out(5, 3);  chk("f2_old_pos", rgb(), 32'hFF0000);
        wait_out(2, 3);  chk("f2_not_new", rgb(), BG);
        cfg.update_req = 1'b1;
        wait_ctr(1, VA); chk("f2_ack", 32'(cfg.update_ack), 32'd1);
        cfg.update_req = 1'b0;
        wait_ctr(2, VA); chk("f2_ack_single", 32'(cfg.update_ack), 32'd0);

        // Frame 3: moved obj0, then request disabling it.
        wait_out(2, 3);  chk("f3_new_pos", rgb(), 32'hFF0000);
        wait_out(6, 3);  chk("f3_old_gone", rgb(), BG);
        wait_out(7, 4);  chk("f3_obj1", rgb(), 32'h00FF00);
        cfg.obj_en[0]   = 1'b0;
        cfg.obj_x[10:0] = 11'd5;
        cfg.update_req  = 1'b1;
        wait_ctr(1, VA); chk("f3_ack", 32'(cfg.update_ack), 32'd1);
        cfg.update_req = 1'b0;

        // Frame 4: obj0 disabled, then mid-frame reset.
        wait_out(5, 3);  chk("f4_obj0_off", rgb(), BG);
        wait_out(7, 4);  chk("f4_overlap_obj1", rgb(), 32'h00FF00);
        wait_ctr(10, 5);
        chk("pre_rst_rgb", rgb(), 32'h00FF00);
        reset = 1'b1;
        #1;
        chk("arst_blank", 32'(blank), 32'd1);
        chk("arst_rgb", rgb(), 32'd0);
        chk("arst_hsync", 32'(hsync), 32'd1);
        chk("arst_vsync", 32'(vsync), 32'd1);
        repeat (2) @(negedge clk);
        cfg.obj_en[0]  = 1'b1;
        cfg.update_req = 1'b1;
        reset   = 1'b0;
        rel_cyc = cyc;

        wait_out(0, 0);
        chk("rr_fs", 32'(frame_start), 32'd1);
        chk("rr_fs_lat", 32'(cyc - rel_cyc), 32'd2);
        wait_out(5, 3);  chk("rr_obj0_cleared", rgb(), BG);
        wait_out(7, 4);  chk("rr_obj1_cleared", rgb(), BG);
        wait_ctr(1, VA); chk("rr_ack", 32'(cfg.update_ack), 32'd1);
        cfg.update_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sprite_video_engine.md
SPRITE_VIDEO_ENGINE -- requirements
Module: sprite_video_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync width and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter NUM_OBJ, default 4, number of rectangular objects (1..16).
REQ-006 SHALL have parameter CW, default 8, bits per colour channel.
REQ-007 pixel_clock  in  1  sole clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 obj_x  in  NUM_OBJ*11  per-object left column, object i at bits [11i+10:11i].
REQ-010 obj_y  in  NUM_OBJ*10  per-object top line.
REQ-011 obj_w  in  NUM_OBJ*11  per-object width in pixels; 0 means invisible.
REQ-012 obj_h  in  NUM_OBJ*10  per-object height in lines; 0 means invisible.
REQ-013 obj_en  in  NUM_OBJ  per-object enable.
REQ-014 obj_rgb  in  NUM_OBJ*3*CW  per-object colour {R,G,B}.
REQ-015 bg_rgb  in  3*CW  background colour {R,G,B}.
REQ-016 update_req  in  1  request to load all obj_* inputs into shadow registers.
REQ-017 update_ack  out  1  one-cycle pulse confirming shadow load.
REQ-018 hsync, vsync  out  1 each  active-low sync.
REQ-019 blank  out  1  high outside the active area.
REQ-020 red, green, blue  out  CW each  pixel colour.
REQ-021 frame_start  out  1  one-cycle pulse coincident with output pixel (0,0).

Function
REQ-022 Horizontal counter h SHALL count 0..H_ACTIVE+H_FP+H_SYNC+H_BP-1, then wrap to 0; vertical counter v SHALL increment on each h wrap and wrap to 0 after V_ACTIVE+V_FP+V_SYNC+V_BP-1 lines.
REQ-023 Raw hsync SHALL be low iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; raw vsync SHALL be low iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
REQ-024 Raw blank SHALL be high iff h >= H_ACTIVE or v >= V_ACTIVE.
REQ-025 Rendering SHALL use only shadow registers, never live obj_* inputs.
REQ-026 Shadow load SHALL occur on the edge where h=0, v=V_ACTIVE and update_req=1; update_ack SHALL pulse high for exactly the following cycle.
REQ-027 update_req low at that edge SHALL leave the shadows unchanged for the whole next frame and produce no ack; the requester holds update_req until it sees update_ack.
REQ-028 Object i SHALL hit iff shadow en_i=1, x_i <= h < x_i+w_i and y_i <= v < y_i+h_i, with sums formed at 12/11 bits so no wrap occurs; objects extending past the active area SHALL be clipped, never wrapped.
REQ-029 On multiple hits the lowest index SHALL win; no hit SHALL select bg_rgb.
REQ-030 Pipeline: stage 1 computes hit vector, stage 2 selects colour; red/green/blue, hsync, vsync, blank and frame_start SHALL all appear exactly 2 cycles after the counters hold the corresponding (h,v).
REQ-031 red/green/blue SHALL be 0 whenever output blank=1.
REQ-032 frame_start SHALL be high for the single output cycle corresponding to h=0, v=0.

Reset
REQ-033 While reset=1: h=0, v=0, all shadow registers 0 (all objects disabled), pipeline cleared; hsync=1, vsync=1, blank=1, red=green=blue=0, update_ack=0, frame_start=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame; after release the counters resume from (0,0), and frame_start SHALL occur 2 cycles after the first counter state (0,0) following release.
REQ-035 A pending update_req at reset SHALL be ignored until the next qualifying h=0, v=V_ACTIVE edge.

Verification
REQ-036 Default params, no updates: hsync low for 96 cycles of each 800-cycle line; vsync low for 2 lines of each 525-line frame; frame_start period 420000 cycles.
REQ-037 Load obj0 x=100, y=50, w=10, h=4, en=1, rgb=FF0000, bg=000020 -> red at columns 100..109 of lines 50..53, 000020 elsewhere in the active area, column 110 background.
REQ-038 obj0 and obj1 overlapping at (200,200), both enabled -> obj0 colour shown; disabling obj0 via update -> obj1 colour from the next frame only.
REQ-039 Change obj_x mid-frame with update_req=0 -> the current and following frames are unchanged; assert update_req -> single update_ack on the cycle after h=0, v=480 edge, new position from the next frame.
REQ-040 obj0 x=635, w=20 -> columns 635..639 coloured; column 0 of the next line is background (no wrap).
REQ-041 Reset pulsed at h=300, v=200 -> outputs at reset values immediately; frame_start 2 cycles after the counters resume at (0,0); shadows are all 0 (only background shown).
